// File: rtl/framing_ctrl.sv
// -----------------------------------------------------------------------------
// framing_ctrl
//
// Sequencer for the single-port framing memory of the MFCC front end.
// Incoming samples are written into the memory as a circular buffer. Once the
// buffer is full, and every HOP samples after that, one complete frame is read
// back oldest-sample-first and streamed to the windowing stage over a
// valid/ready interface. Sample writes always own the memory port; frame reads
// only use cycles in which no sample arrives.
//
// Ports:
//   clk           clock
//   rst           asynchronous active-high reset
//   sample_valid  one sample presented this cycle (no backpressure)
//   sample_in     sample data
//   mem_wen       memory write enable (1 write, 0 read)
//   mem_a         memory address
//   mem_d         memory write data
//   mem_q         memory combinational read data for mem_a
//   out_valid     frame sample valid
//   out_data      frame sample
//   out_last      marks the final sample of a frame
//   out_ready     downstream accept
//   busy          frame readout in progress
//   overrun       sticky: a write landed on an unread sample of the active frame
//   frame_drop    sticky: a frame trigger arrived while a readout was active
// -----------------------------------------------------------------------------
module framing_ctrl #(
    parameter int BITS  = 12,
    parameter int DEPTH = 128,
    parameter int HOP   = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_valid,
    input  logic [BITS-1:0] sample_in,
    output logic            mem_wen,
    output logic [6:0]      mem_a,
    output logic [BITS-1:0] mem_d,
    input  logic [BITS-1:0] mem_q,
    output logic            out_valid,
    output logic [BITS-1:0] out_data,
    output logic            out_last,
    input  logic            out_ready,
    output logic            busy,
    output logic            overrun,
    output logic            frame_drop
);

    localparam logic [6:0] LAST_POS = 7'(DEPTH - 1);
    localparam logic [6:0] HOP_LAST = 7'(HOP - 1);

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t          state_q;
    logic [6:0]      wr_ptr_q;
    logic [6:0]      fill_cnt_q;
    logic            primed_q;
    logic [6:0]      hop_cnt_q;
    logic [6:0]      rd_base_q;
    logic [6:0]      rd_cnt_q;
    // Writes since the active frame started; saturates so a long stall
    // cannot wrap it back below rd_cnt_q and hide an overrun.
    logic [7:0]      wr_since_q;
    logic            out_valid_q;
    logic [BITS-1:0] out_data_q;
    logic            out_last_q;
    logic            overrun_q;
    logic            frame_drop_q;

    logic            wr_en;
    logic            issue;
    logic            accept;
    logic            trigger;
    logic            unread_hit;
    logic [6:0]      rd_addr;
    logic [7:0]      wr_since_d;

    // NOTE: every signal gets a value on every path through this block, so no
    // latch is inferred.
    always_comb begin
        // Writes are suppressed while reset is held so the memory is never
        // touched while the pointers are pinned at zero.
        wr_en      = sample_valid & ~rst;
        accept     = out_valid_q & out_ready;
        issue      = (state_q == READ) & ~sample_valid & (~out_valid_q | out_ready);
        trigger    = wr_en & (primed_q ? (hop_cnt_q == HOP_LAST)
                                       : (fill_cnt_q == LAST_POS));
        // 7-bit add wraps naturally around the 128-entry ring.
        rd_addr    = rd_base_q + rd_cnt_q;
        // The n-th write after a frame start lands on frame position n; that
        // position is still unread when n >= rd_cnt.
        unread_hit = wr_en & (state_q == READ) & (wr_since_q >= {1'b0, rd_cnt_q});
        wr_since_d = (wr_since_q == 8'hFF) ? wr_since_q : wr_since_q + 8'd1;

        mem_wen    = wr_en;
        mem_d      = wr_en ? sample_in : '0;
        mem_a      = issue ? rd_addr : wr_ptr_q;
    end

    // NOTE: state is updated with non-blocking assignments only; where two
    // assignments to the same register fire in one cycle, the later one wins.
    // The memory itself lives outside this block and is not reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            fill_cnt_q   <= '0;
            primed_q     <= 1'b0;
            hop_cnt_q    <= '0;
            rd_base_q    <= '0;
            rd_cnt_q     <= '0;
            wr_since_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            overrun_q    <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            // ---------------- write side ----------------
            if (wr_en) begin
                wr_ptr_q   <= wr_ptr_q + 7'd1;
                wr_since_q <= wr_since_d;
                if (!primed_q) begin
                    if (trigger) begin
                        primed_q <= 1'b1;
                    end else begin
                        fill_cnt_q <= fill_cnt_q + 7'd1;
                    end
                end else begin
                    // hop_cnt clears on every trigger, including dropped ones,
                    // so the frame cadence stays locked to the sample stream.
                    hop_cnt_q <= trigger ? '0 : hop_cnt_q + 7'd1;
                end
                if (unread_hit) begin
                    overrun_q <= 1'b1;
                end
                if (trigger && state_q == READ) begin
                    frame_drop_q <= 1'b1;
                end
            end

            // ---------------- frame sequencer ----------------
            case (state_q)
                IDLE: begin
                    if (trigger) begin
                        // Oldest sample sits just after the one being written.
                        rd_base_q  <= wr_ptr_q + 7'd1;
                        rd_cnt_q   <= '0;
                        // The triggering write precedes the frame, so the
                        // post-start write count begins at zero.
                        wr_since_q <= '0;
                        state_q    <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        rd_cnt_q <= rd_cnt_q + 7'd1;
                        if (rd_cnt_q == LAST_POS) begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // ---------------- output register ----------------
            if (issue) begin
                out_data_q  <= mem_q;
                out_valid_q <= 1'b1;
                out_last_q  <= (rd_cnt_q == LAST_POS);
            end else if (accept) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_last   = out_last_q;
    // Stays high until the final beat has actually been taken downstream.
    assign busy       = (state_q == READ) | (out_valid_q & out_last_q);
    assign overrun    = overrun_q;
    assign frame_drop = frame_drop_q;

endmodule
